// File: rtl/fp_sub_align_stage_if.sv
// Operand/result handshake bundle between the FP32 pre-alignment stage and its neighbours.
// master drives operands and consumes results; slave is the alignment stage itself.
interface fp_sub_align_stage_if;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] a;
   logic [31:0] b;
   logic        op;
   logic        out_valid;
   logic        out_ready;
   logic        out_sign;
   logic        out_eff_sub;
   logic [7:0]  out_exp;
   logic [26:0] out_mant_l;
   logic [26:0] out_mant_s;
   logic        out_special;
   logic [31:0] out_special_val;

   modport master (
      output in_valid, a, b, op, out_ready,
      input  in_ready, out_valid, out_sign, out_eff_sub, out_exp,
             out_mant_l, out_mant_s, out_special, out_special_val
   );

   modport slave (
      input  in_valid, a, b, op, out_ready,
      output in_ready, out_valid, out_sign, out_eff_sub, out_exp,
             out_mant_l, out_mant_s, out_special, out_special_val
   );
endinterface

// File: rtl/fp_sub_align_stage.sv
// FP32 add/sub pre-alignment: unpack, apply subtract flip, resolve NaN/Inf, swap by
// magnitude and shift the small significand right a few bits per cycle with sticky.
module fp_sub_align_stage #(
   parameter int SHIFT_STEP     = 4,
   parameter int FAST_SHIFT_MIN = 27
) (
   input logic                  clk,
   input logic                  rst_n,
   fp_sub_align_stage_if.slave  bus
);
   localparam logic [7:0] STEP_W = 8'(SHIFT_STEP);
   localparam logic [7:0] FAST_W = 8'(FAST_SHIFT_MIN);

   typedef enum logic [1:0] {IDLE, ALIGN, DONE} state_t;
   state_t state_q, state_d;

   logic [26:0] mant_l_q, mant_s_q, mant_s_d;
   logic [7:0]  exp_q, rem_q, rem_d, k;
   logic        sign_q, eff_sub_q, special_q;
   logic [31:0] special_val_q;

   logic        sign_a, sign_b, hid_a, hid_b, a_large;
   logic [7:0]  exp_a, exp_b, eexp_a, eexp_b, eexp_l, eexp_s, d;
   logic [22:0] frac_a, frac_b;
   logic [26:0] ld_a, ld_b, ld_l, ld_s, shifted, lost_mask;
   logic        nan_a, nan_b, inf_a, inf_b, special, fast, accept;
   logic [31:0] special_val;

   assign sign_a  = bus.a[31];
   assign sign_b  = bus.b[31] ^ bus.op;
   assign exp_a   = bus.a[30:23];
   assign exp_b   = bus.b[30:23];
   assign frac_a  = bus.a[22:0];
   assign frac_b  = bus.b[22:0];
   assign hid_a   = |exp_a;
   assign hid_b   = |exp_b;
   assign eexp_a  = hid_a ? exp_a : 8'd1;
   assign eexp_b  = hid_b ? exp_b : 8'd1;
   assign ld_a    = {hid_a, frac_a, 3'b000};
   assign ld_b    = {hid_b, frac_b, 3'b000};
   assign a_large = bus.a[30:0] >= bus.b[30:0];
   assign ld_l    = a_large ? ld_a : ld_b;
   assign ld_s    = a_large ? ld_b : ld_a;
   assign eexp_l  = a_large ? eexp_a : eexp_b;
   assign eexp_s  = a_large ? eexp_b : eexp_a;
   assign d       = eexp_l - eexp_s;
   assign fast    = d >= FAST_W;

   assign nan_a   = (&exp_a) && (|frac_a);
   assign nan_b   = (&exp_b) && (|frac_b);
   assign inf_a   = (&exp_a) && !(|frac_a);
   assign inf_b   = (&exp_b) && !(|frac_b);
   assign special = (&exp_a) || (&exp_b);

   always_comb begin
      special_val = 32'h0;
      if (nan_a || nan_b)
         special_val = 32'hFFC00000;
      else if (inf_a && inf_b && (sign_a != sign_b))
         special_val = 32'hFFC00000;
      else if (inf_a)
         special_val = {sign_a, 8'hFF, 23'h0};
      else if (inf_b)
         special_val = {sign_b, 8'hFF, 23'h0};
   end

   // Bits leaving the bottom of the significand fold into bit 0 as sticky.
   assign k         = (rem_q < STEP_W) ? rem_q : STEP_W;
   assign shifted   = mant_s_q >> k;
   assign lost_mask = (27'h1 << k) - 27'h1;
   assign mant_s_d  = {shifted[26:1], shifted[0] | (|(mant_s_q & lost_mask))};
   assign rem_d     = rem_q - k;

   assign accept = (state_q == IDLE) && bus.in_valid;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (bus.in_valid)
                     state_d = (special || d == 8'd0 || fast) ? DONE : ALIGN;
         ALIGN:   if (rem_q <= STEP_W) state_d = DONE;
         DONE:    if (bus.out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      bus.in_ready  = rst_n && (state_q == IDLE);
      bus.out_valid = (state_q == DONE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mant_l_q      <= '0;
         mant_s_q      <= '0;
         exp_q         <= '0;
         rem_q         <= '0;
         sign_q        <= 1'b0;
         eff_sub_q     <= 1'b0;
         special_q     <= 1'b0;
         special_val_q <= '0;
      end else if (accept) begin
         special_q     <= special;
         special_val_q <= special_val;
         if (special) begin
            mant_l_q  <= '0;
            mant_s_q  <= '0;
            exp_q     <= '0;
            rem_q     <= '0;
            sign_q    <= 1'b0;
            eff_sub_q <= 1'b0;
         end else begin
            mant_l_q  <= ld_l;
            mant_s_q  <= fast ? {26'h0, |ld_s} : ld_s;
            exp_q     <= eexp_l;
            rem_q     <= fast ? 8'd0 : d;
            sign_q    <= a_large ? sign_a : sign_b;
            eff_sub_q <= sign_a ^ sign_b;
         end
      end else if (state_q == ALIGN) begin
         mant_s_q <= mant_s_d;
         rem_q    <= rem_d;
      end
   end

   assign bus.out_sign        = sign_q;
   assign bus.out_eff_sub     = eff_sub_q;
   assign bus.out_exp         = exp_q;
   assign bus.out_mant_l      = mant_l_q;
   assign bus.out_mant_s      = mant_s_q;
   assign bus.out_special     = special_q;
   assign bus.out_special_val = special_val_q;
endmodule

// File: tb/tb_fp_sub_align_stage.sv
// Directed-vector bench for fp_sub_align_stage with hand-computed expectations.
module tb_fp_sub_align_stage;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_chk = 0;
   int   n_bad = 0;

   fp_sub_align_stage_if bus();

   fp_sub_align_stage dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic op,
                        output int lat);
      @(negedge clk);
      bus.a = a; bus.b = b; bus.op = op; bus.in_valid = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      lat = 1;
      while (!bus.out_valid && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic release_out(input string tag);
      @(negedge clk);
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      chk({tag, ".idle_ov"}, {31'h0, bus.out_valid}, 32'h0);
      chk({tag, ".idle_rdy"}, {31'h0, bus.in_ready}, 32'h1);
   endtask

   task automatic run_vec(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic op, input int e_lat, input logic e_sign,
                          input logic e_eff, input logic [7:0] e_exp,
                          input logic [26:0] e_ml, input logic [26:0] e_ms,
                          input logic e_sp, input logic [31:0] e_spv);
      int lat;
      issue(a, b, op, lat);
      chk({tag, ".lat"},  32'(lat), 32'(e_lat));
      chk({tag, ".sign"}, {31'h0, bus.out_sign}, {31'h0, e_sign});
      chk({tag, ".eff"},  {31'h0, bus.out_eff_sub}, {31'h0, e_eff});
      chk({tag, ".exp"},  {24'h0, bus.out_exp}, {24'h0, e_exp});
      chk({tag, ".ml"},   {5'h0, bus.out_mant_l}, {5'h0, e_ml});
      chk({tag, ".ms"},   {5'h0, bus.out_mant_s}, {5'h0, e_ms});
      chk({tag, ".sp"},   {31'h0, bus.out_special}, {31'h0, e_sp});
      chk({tag, ".spv"},  bus.out_special_val, e_spv);
      release_out(tag);
   endtask

   initial begin
      int  lat;
      bit  stale;
      bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.op = 1'b0; bus.out_ready = 1'b0;
      #12;
      chk("rst.ov",  {31'h0, bus.out_valid}, 32'h0);
      chk("rst.rdy", {31'h0, bus.in_ready}, 32'h0);
      chk("rst.ml",  {5'h0, bus.out_mant_l}, 32'h0);
      @(negedge clk); rst_n = 1'b1; #1;
      chk("rst.rdy_rel", {31'h0, bus.in_ready}, 32'h1);

      //       tag       a             b             op  lat sgn eff exp    mant_l        mant_s        sp  spv
      run_vec("3m2",    32'h40400000, 32'h40000000, 1, 1, 0, 1, 8'h80, 27'h6000000, 27'h4000000, 0, 32'h0);
      run_vec("2m3",    32'h40000000, 32'h40400000, 1, 1, 1, 1, 8'h80, 27'h6000000, 27'h4000000, 0, 32'h0);
      run_vec("100m3",  32'h42C80000, 32'h3EAAAAAB, 1, 3, 0, 1, 8'h85, 27'h6400000, 27'h0055555, 0, 32'h0);
      run_vec("32p1",   32'h42000000, 32'h3F800000, 0, 3, 0, 0, 8'h84, 27'h4000000, 27'h0200000, 0, 32'h0);
      run_vec("d26",    32'h4C800000, 32'h3F800001, 0, 8, 0, 0, 8'h99, 27'h4000000, 27'h0000001, 0, 32'h0);
      run_vec("d27",    32'h4D000000, 32'h3F800000, 0, 1, 0, 0, 8'h9A, 27'h4000000, 27'h0000001, 0, 32'h0);
      run_vec("fast30", 32'h3F800000, 32'h30800000, 1, 1, 0, 1, 8'h7F, 27'h4000000, 27'h0000001, 0, 32'h0);
      run_vec("m10m10", 32'hC1200000, 32'h41200000, 1, 1, 1, 0, 8'h82, 27'h5000000, 27'h5000000, 0, 32'h0);
      run_vec("zero",   32'h40000000, 32'h00000000, 1, 1, 0, 1, 8'h80, 27'h4000000, 27'h0000000, 0, 32'h0);
      run_vec("infinf", 32'h7F800000, 32'h7F800000, 1, 1, 0, 0, 8'h00, 27'h0,       27'h0,       1, 32'hFFC00000);
      run_vec("infm2",  32'h7F800000, 32'h40000000, 1, 1, 0, 0, 8'h00, 27'h0,       27'h0,       1, 32'h7F800000);
      run_vec("ninfm2", 32'hFF800000, 32'h40000000, 1, 1, 0, 0, 8'h00, 27'h0,       27'h0,       1, 32'hFF800000);
      run_vec("nan",    32'h7FC00000, 32'h3F800000, 0, 1, 0, 0, 8'h00, 27'h0,       27'h0,       1, 32'hFFC00000);

      // Backpressure: result must hold while a competing operand is offered.
      issue(32'h40400000, 32'h40000000, 1'b1, lat);
      chk("bp.lat", 32'(lat), 32'd1);
      @(negedge clk);
      bus.a = 32'h3F800000; bus.b = 32'h3F800000; bus.op = 1'b0; bus.in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         chk("bp.ov",  {31'h0, bus.out_valid}, 32'h1);
         chk("bp.rdy", {31'h0, bus.in_ready}, 32'h0);
         chk("bp.ml",  {5'h0, bus.out_mant_l}, {5'h0, 27'h6000000});
         chk("bp.ms",  {5'h0, bus.out_mant_s}, {5'h0, 27'h4000000});
         chk("bp.exp", {24'h0, bus.out_exp}, 32'h80);
      end
      @(negedge clk); bus.in_valid = 1'b0;
      release_out("bp");
      run_vec("bp_next", 32'h42000000, 32'h3F800000, 0, 3, 0, 0, 8'h84, 27'h4000000, 27'h0200000, 0, 32'h0);

      // Reset during the second ALIGN cycle of the d=8 case.
      @(negedge clk);
      bus.a = 32'h42C80000; bus.b = 32'h3EAAAAAB; bus.op = 1'b1; bus.in_valid = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      chk("mrst.ml_pre", {5'h0, bus.out_mant_l}, {5'h0, 27'h6400000});
      @(posedge clk); #2;
      rst_n = 1'b0; #1;
      chk("mrst.ml",  {5'h0, bus.out_mant_l}, 32'h0);
      chk("mrst.ms",  {5'h0, bus.out_mant_s}, 32'h0);
      chk("mrst.exp", {24'h0, bus.out_exp}, 32'h0);
      chk("mrst.eff", {31'h0, bus.out_eff_sub}, 32'h0);
      chk("mrst.ov",  {31'h0, bus.out_valid}, 32'h0);
      chk("mrst.rdy", {31'h0, bus.in_ready}, 32'h0);
      @(negedge clk); rst_n = 1'b1; #1;
      chk("mrst.rdy_rel", {31'h0, bus.in_ready}, 32'h1);
      stale = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         if (bus.out_valid) stale = 1'b1;
      end
      chk("mrst.stale", {31'h0, stale}, 32'h0);
      run_vec("post_rst", 32'h40400000, 32'h40000000, 1, 1, 0, 1, 8'h80, 27'h6000000, 27'h4000000, 0, 32'h0);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end
endmodule
